// File: rtl/pll_drp_pkg.sv
// Shared types and constants for the PLL feedback-multiplier DRP sequencer.
// Holds the FSM encoding, DRP register map, keep masks, error codes and legal range.
package pll_drp_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_CHK   = 4'd1,
    S_RSTA  = 4'd2,
    S_RD    = 4'd3,
    S_RDW   = 4'd4,
    S_WR    = 4'd5,
    S_WRW   = 4'd6,
    S_RSTR  = 4'd7,
    S_LOCKW = 4'd8,
    S_FIN   = 4'd9
  } state_t;

  localparam logic [6:0]  REG1_ADDR = 7'h14;
  localparam logic [6:0]  REG2_ADDR = 7'h15;
  localparam logic [15:0] REG1_KEEP = 16'hF000;
  localparam logic [15:0] REG2_KEEP = 16'hFF3F;

  localparam logic [1:0]  ERR_NONE  = 2'd0;
  localparam logic [1:0]  ERR_RANGE = 2'd1;
  localparam logic [1:0]  ERR_DRDY  = 2'd2;
  localparam logic [1:0]  ERR_LOCK  = 2'd3;

  localparam logic [6:0]  MULT_MIN  = 7'd2;
  localparam logic [6:0]  MULT_MAX  = 7'd64;

  function automatic logic mult_legal(input logic [6:0] m);
    return (m >= MULT_MIN) && (m <= MULT_MAX);
  endfunction

  // Read-modify-write: keep the bits the mask protects, OR in the new field.
  function automatic logic [15:0] merge_word(input logic [15:0] rd,
                                             input logic [15:0] keep,
                                             input logic [15:0] field);
    return (rd & keep) | field;
  endfunction

endpackage

// File: rtl/pll_drp_seq_if.sv
// Bundle of the request/status signals towards the UI and the DRP/PLL signals.
// master = sequencer side, slave = UI controller plus PLL primitive side.
interface pll_drp_seq_if;
  // req is a level request taken only while busy is low; busy covers the whole
  // operation up to and including the done/err pulse. On the DRP side each den
  // pulse opens one access (dwe marks a write) and drdy closes it.
  logic        req;
  logic [6:0]  mult;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [6:0]  cur_mult;
  logic [6:0]  daddr;
  logic [15:0] di;
  logic [15:0] drp_do;
  logic        den;
  logic        dwe;
  logic        drdy;
  logic        pll_rst;
  logic        locked;

  modport master (
    input  req, mult, drp_do, drdy, locked,
    output busy, done, err, err_code, cur_mult, daddr, di, den, dwe, pll_rst
  );

  modport slave (
    output req, mult, drp_do, drdy, locked,
    input  busy, done, err, err_code, cur_mult, daddr, di, den, dwe, pll_rst
  );
endinterface

// File: rtl/pll_div_calc.sv
// Registered divider math: multiplier M -> CLKFBOUT reg1 counter field and reg2 edge/nocount bits.
// Only the low 6 bits of HI/LO matter because M never exceeds 64 once accepted.
module pll_div_calc
  import pll_drp_pkg::*;
(
  input  logic        clk,
  input  logic        rstx,
  input  logic [6:0]  mult,
  output logic [11:0] reg1_field,
  output logic [1:0]  reg2_field
);

  logic [5:0] hi;
  logic [5:0] lo;

  always_comb begin
    hi = mult[6:1];
    lo = mult[5:0] - hi;
  end

  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      reg1_field <= '0;
      reg2_field <= '0;
    end else begin
      reg1_field <= {hi, lo};
      reg2_field <= {mult[0], 1'b0};
    end
  end

endmodule

// File: rtl/pll_drp_seq.sv
// Sequencer that holds the PLL in reset, read-modify-writes CLKFBOUT reg1/reg2 over DRP,
// then releases reset and waits for a synchronised lock. All bus outputs are registered.
module pll_drp_seq
  import pll_drp_pkg::*;
#(
  parameter logic [6:0]  INIT_MULT = 7'd10,
  parameter logic [7:0]  DRDY_TO   = 8'd255,
  parameter logic [19:0] LOCK_TO   = 20'd999999
) (
  input  logic          clk,
  input  logic          rstx,
  pll_drp_seq_if.master bus,
  output state_t        dbg_state
);

  state_t      state, state_d;
  logic [6:0]  m_q, m_d;
  logic        sel_q, sel_d;
  logic [15:0] rd_q, rd_d;
  logic [19:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [6:0]  cur_mult_q, cur_mult_d;
  logic [6:0]  daddr_q, daddr_d;
  logic [15:0] di_q, di_d;
  logic        den_q, den_d;
  logic        dwe_q, dwe_d;
  logic        pll_rst_q, pll_rst_d;
  logic        lock_meta, lock_sync;
  logic        wait_state, drdy_expired, lock_expired;
  logic [11:0] reg1_field;
  logic [1:0]  reg2_field;

  pll_div_calc u_div (
    .clk        (clk),
    .rstx       (rstx),
    .mult       (m_q),
    .reg1_field (reg1_field),
    .reg2_field (reg2_field)
  );

  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      lock_meta <= bus.locked;
      lock_sync <= lock_meta;
    end
  end

  // One counter serves every wait state; it restarts on each state change.
  always_comb begin
    wait_state   = (state == S_RDW) || (state == S_WRW) || (state == S_LOCKW);
    drdy_expired = (cnt_q == ({12'd0, DRDY_TO} - 20'd1));
    lock_expired = (cnt_q == (LOCK_TO - 20'd1));
  end

  always_comb begin
    state_d    = state;
    m_d        = m_q;
    sel_d      = sel_q;
    rd_d       = rd_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    cur_mult_d = cur_mult_q;
    daddr_d    = daddr_q;
    di_d       = di_q;
    den_d      = 1'b0;
    dwe_d      = 1'b0;
    pll_rst_d  = pll_rst_q;
    unique case (state)
      S_IDLE: begin
        if (bus.req) begin
          m_d     = bus.mult;
          busy_d  = 1'b1;
          state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (!mult_legal(m_q)) begin
          err_d      = 1'b1;
          err_code_d = ERR_RANGE;
          state_d    = S_FIN;
        end else begin
          sel_d   = 1'b0;
          state_d = S_RSTA;
        end
      end
      S_RSTA: begin
        pll_rst_d = 1'b1;
        state_d   = S_RD;
      end
      S_RD: begin
        den_d   = 1'b1;
        daddr_d = sel_q ? REG2_ADDR : REG1_ADDR;
        state_d = S_RDW;
      end
      S_RDW: begin
        if (bus.drdy) begin
          rd_d    = bus.drp_do;
          state_d = S_WR;
        end else if (drdy_expired) begin
          pll_rst_d  = 1'b0;
          err_d      = 1'b1;
          err_code_d = ERR_DRDY;
          state_d    = S_FIN;
        end
      end
      S_WR: begin
        den_d   = 1'b1;
        dwe_d   = 1'b1;
        di_d    = sel_q ? merge_word(rd_q, REG2_KEEP, {8'h00, reg2_field, 6'b0})
                        : merge_word(rd_q, REG1_KEEP, {4'h0, reg1_field});
        state_d = S_WRW;
      end
      S_WRW: begin
        if (bus.drdy) begin
          if (sel_q) begin
            state_d = S_RSTR;
          end else begin
            sel_d   = 1'b1;
            state_d = S_RD;
          end
        end else if (drdy_expired) begin
          pll_rst_d  = 1'b0;
          err_d      = 1'b1;
          err_code_d = ERR_DRDY;
          state_d    = S_FIN;
        end
      end
      S_RSTR: begin
        pll_rst_d = 1'b0;
        state_d   = S_LOCKW;
      end
      S_LOCKW: begin
        if (lock_sync) begin
          done_d     = 1'b1;
          cur_mult_d = m_q;
          state_d    = S_FIN;
        end else if (lock_expired) begin
          err_d      = 1'b1;
          err_code_d = ERR_LOCK;
          state_d    = S_FIN;
        end
      end
      S_FIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    cnt_d = (wait_state && (state_d == state)) ? cnt_q + 20'd1 : 20'd0;
  end

  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      state      <= S_IDLE;
      m_q        <= INIT_MULT;
      sel_q      <= 1'b0;
      rd_q       <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      cur_mult_q <= INIT_MULT;
      daddr_q    <= '0;
      di_q       <= '0;
      den_q      <= 1'b0;
      dwe_q      <= 1'b0;
      pll_rst_q  <= 1'b0;
    end else begin
      state      <= state_d;
      m_q        <= m_d;
      sel_q      <= sel_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      cur_mult_q <= cur_mult_d;
      daddr_q    <= daddr_d;
      di_q       <= di_d;
      den_q      <= den_d;
      dwe_q      <= dwe_d;
      pll_rst_q  <= pll_rst_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.err_code = err_code_q;
  assign bus.cur_mult = cur_mult_q;
  assign bus.daddr    = daddr_q;
  assign bus.di       = di_q;
  assign bus.den      = den_q;
  assign bus.dwe      = dwe_q;
  assign bus.pll_rst  = pll_rst_q;
  assign dbg_state    = state;

endmodule
